// File: rtl/alu_share_arb.sv
// Two requesters share one ALU: round-robin grant in IDLE, operand capture,
// a LATENCY-cycle wait, then a held result tagged with its source port.
module alu_share_arb #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [31:0] r0_a,
   input  logic [31:0] r0_b,
   input  logic [3:0]  r0_op,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [31:0] r1_a,
   input  logic [31:0] r1_b,
   input  logic [3:0]  r1_op,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_src,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic        prio;
   logic [3:0]  count;
   logic [31:0] cap_a;
   logic [31:0] cap_b;
   logic [3:0]  cap_op;
   logic        cap_src;
   logic        grant;
   logic        accept;

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y;
      y = 32'h0;
      case (op)
         4'b0000: y = a + b;
         4'b0001: y = a - b;
         4'b0010: y = a & b;
         4'b0011: y = a | b;
         4'b0100: y = {b[15:0], 16'h0};
         4'b0101: y = ~(a | b);
         4'b0110: y = a ^ b;
         4'b0111: y = b << a[4:0];
         4'b1000: y = b >> a[4:0];
         4'b1001: y = $signed(b) >>> a[4:0];
         4'b1010: y = {31'h0, $signed(a) < $signed(b)};
         4'b1011: y = {31'h0, a < b};
         4'b1100: y = a + b;
         4'b1111: y = a;
         default: y = 32'h0;
      endcase
      return y;
   endfunction

   // Grant and same-cycle ready; only the granted port sees ready, only in IDLE.
   always_comb begin
      grant    = (r0_valid & r1_valid) ? prio : r1_valid;
      r0_ready = 1'b0;
      r1_ready = 1'b0;
      if (!reset && state == IDLE) begin
         r0_ready = r0_valid & ~grant;
         r1_ready = r1_valid & grant;
      end else begin
         r0_ready = 1'b0;
         r1_ready = 1'b0;
      end
      accept = r0_ready | r1_ready;
   end

   // Control FSM, operand capture and the registered result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         prio      <= 1'b0;
         count     <= 4'd0;
         cap_a     <= 32'h0;
         cap_b     <= 32'h0;
         cap_op    <= 4'd0;
         cap_src   <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= 32'h0;
         res_src   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_a   <= grant ? r1_a  : r0_a;
                  cap_b   <= grant ? r1_b  : r0_b;
                  cap_op  <= grant ? r1_op : r0_op;
                  cap_src <= grant;
                  prio    <= ~grant;
                  count   <= 4'(LATENCY - 1);
                  busy    <= 1'b1;
                  state   <= (LATENCY == 1) ? DONE : BUSY;
               end
            end
            BUSY: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle computes the result; afterwards it is held until taken.
               if (!res_valid) begin
                  res_data  <= alu(cap_op, cap_a, cap_b);
                  res_src   <= cap_src;
                  res_valid <= 1'b1;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: LATENCY=1 instance for function and
// arbitration, LATENCY=4 instance for timing and mid-operation reset.
module tb_alu_share_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [3:0]  r0_op, r1_op;
   logic        res_valid, res_ready, res_src, busy;
   logic [31:0] res_data;

   logic        d4_r0_valid, d4_r0_ready, d4_r1_valid, d4_r1_ready;
   logic [31:0] d4_r0_a, d4_r0_b, d4_r1_a, d4_r1_b;
   logic [3:0]  d4_r0_op, d4_r1_op;
   logic        d4_res_valid, d4_res_ready, d4_res_src, d4_busy;
   logic [31:0] d4_res_data;

   int checks = 0;
   int errors = 0;
   bit prio_m;

   alu_share_arb #(.LATENCY(1)) dut (
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src),
      .busy(busy)
   );

   alu_share_arb #(.LATENCY(4)) dut4 (
      .clk(clk), .reset(reset),
      .r0_valid(d4_r0_valid), .r0_ready(d4_r0_ready), .r0_a(d4_r0_a), .r0_b(d4_r0_b), .r0_op(d4_r0_op),
      .r1_valid(d4_r1_valid), .r1_ready(d4_r1_ready), .r1_a(d4_r1_a), .r1_b(d4_r1_b), .r1_op(d4_r1_op),
      .res_valid(d4_res_valid), .res_ready(d4_res_ready), .res_data(d4_res_data), .res_src(d4_res_src),
      .busy(d4_busy)
   );

   // Reference ALU: shifts expressed as multiply/divide by powers of two.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [31:0] p2;
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      p2   = 32'd1 << a[4:0];
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = {b[15:0], 16'h0000};
         4'd5:  r = ~(a | b);
         4'd6:  r = a ^ b;
         4'd7:  r = b * p2;
         4'd8:  r = b / p2;
         4'd9:  r = (b / p2) | (b[31] ? ~(ones >> a[4:0]) : 32'h0);
         4'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd11: r = (a < b) ? 32'd1 : 32'd0;
         4'd12: r = a + b;
         4'd15: r = a;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 3))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic set_port(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      if (p) begin r1_a = a; r1_b = b; r1_op = op; end
      else   begin r0_a = a; r0_b = b; r0_op = op; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      prio_m = 1'b0;
   endtask

   // Issue one op on dut, wait for its result; returns ok=0 on an expired bound.
   task automatic run_op(input bit port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input bit consume, output bit ok, output logic [31:0] data, output bit src, output int lat);
      ok = 1'b0; data = 32'h0; src = 1'b0; lat = 0;
      set_port(port, a, b, op);
      if (port) r1_valid = 1'b1; else r0_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (port ? r1_ready : r0_ready) ok = 1'b1;
      end
      if (!ok) begin r0_valid = 1'b0; r1_valid = 1'b0; return; end
      @(posedge clk);
      prio_m = ~port;
      #1;
      r0_valid = 1'b0; r1_valid = 1'b0;
      set_port(port, 32'($urandom), 32'($urandom), 4'($urandom));
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); lat++; #1;
         if (res_valid) ok = 1'b1;
      end
      if (!ok) return;
      data = res_data; src = res_src;
      if (consume) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1; d4_r0_valid = 1'b1; d4_r1_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({r0_ready, r1_ready, res_valid, res_src, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready0/ready1/res_valid/res_src/busy=%b required 00000",
                  {r0_ready, r1_ready, res_valid, res_src, busy});
      end
      checks++;
      if (res_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", res_data); end
      checks++;
      if ({d4_r0_ready, d4_r1_ready, d4_res_valid, d4_busy} !== 4'b0) begin
         errors++;
         $display("FAIL reset_d4: got %b required 0000", {d4_r0_ready, d4_r1_ready, d4_res_valid, d4_busy});
      end
      d4_r0_valid = 1'b0; d4_r1_valid = 1'b0;
      do_reset();
   endtask

   task automatic test_basic();
      bit ok, src; logic [31:0] data; int lat;
      run_op(1'b0, 32'd5, 32'd3, 4'b0000, 1'b1, ok, data, src, lat);
      checks++;
      if (!ok || lat != 1) begin errors++; $display("FAIL basic_latency: ok=%0d lat=%0d required 1", ok, lat); end
      checks++;
      if (data !== 32'd8 || src !== 1'b0) begin
         errors++; $display("FAIL basic_result: data=%h src=%0d required 8 src 0", data, src);
      end
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle: res_valid=%0d busy=%0d required 0 0", res_valid, busy);
      end
   endtask

   task automatic test_round_robin(input int n, input bit fixed);
      int g0 = 0, g1 = 0;
      if (fixed) begin
         set_port(1'b0, 32'd10, 32'd3, 4'b0001);
         set_port(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1010);
      end else begin
         set_port(1'b0, rand_word(), rand_word(), 4'($urandom));
         set_port(1'b1, rand_word(), rand_word(), 4'($urandom));
      end
      r0_valid = 1'b1; r1_valid = 1'b1;
      for (int k = 0; k < n; k++) begin
         bit seen, got, g;
         logic [31:0] exp;
         int lat;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (r0_ready | r1_ready) seen = 1'b1;
         end
         checks++;
         if (!seen || {r0_ready, r1_ready} !== (prio_m ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL rr_grant round %0d: ready0/ready1=%b required %b", k, {r0_ready, r1_ready},
                     prio_m ? 2'b01 : 2'b10);
         end
         if (!seen) break;
         g   = r1_ready;
         exp = g ? ref_alu(r1_op, r1_a, r1_b) : ref_alu(r0_op, r0_a, r0_b);
         if (fixed) exp = (k == 0) ? 32'd7 : 32'd1;
         @(posedge clk);
         prio_m = ~g;
         if (g) g1++; else g0++;
         #1;
         set_port(g, rand_word(), rand_word(), 4'($urandom));
         got = 1'b0; lat = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); lat++; #1;
            if (res_valid) got = 1'b1;
         end
         checks++;
         if (!got || lat != 1 || res_data !== exp || res_src !== g) begin
            errors++;
            $display("FAIL rr_result round %0d: valid=%0d lat=%0d data=%h src=%0d required lat 1 data %h src %0d",
                     k, got, lat, res_data, res_src, exp, g);
         end
         @(posedge clk); #1;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      checks++;
      if (g0 < n / 2 || g1 < n / 2) begin
         errors++; $display("FAIL rr_fairness: grants port0=%0d port1=%0d required %0d each", g0, g1, n / 2);
      end
   endtask

   task automatic test_shifts();
      logic [3:0]  ops [4] = '{4'b1001, 4'b0111, 4'b0100, 4'b1101};
      logic [31:0] as  [4] = '{32'd4, 32'h25, 32'h0, 32'h1234_5678};
      logic [31:0] bs  [4] = '{32'h8000_0000, 32'd1, 32'h1234, 32'hFFFF_FFFF};
      logic [31:0] exs [4] = '{32'hF800_0000, 32'h20, 32'h1234_0000, 32'h0};
      for (int i = 0; i < 4; i++) begin
         bit ok, src; logic [31:0] data; int lat;
         run_op(1'b0, as[i], bs[i], ops[i], 1'b1, ok, data, src, lat);
         checks++;
         if (!ok || data !== exs[i]) begin
            errors++; $display("FAIL shift_vec %0d: ok=%0d data=%h required %h", i, ok, data, exs[i]);
         end
      end
   endtask

   task automatic test_random_ops();
      for (int i = 0; i < 30; i++) begin
         bit ok, src, p; logic [31:0] data, a, b, exp; logic [3:0] op; int lat;
         p = 1'($urandom); a = rand_word(); b = rand_word(); op = 4'($urandom);
         exp = ref_alu(op, a, b);
         run_op(p, a, b, op, 1'b1, ok, data, src, lat);
         checks++;
         if (!ok || lat != 1 || data !== exp || src !== p) begin
            errors++;
            $display("FAIL random_op %0d: op=%h ok=%0d lat=%0d data=%h src=%0d required %h src %0d",
                     i, op, ok, lat, data, src, exp, p);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok, src; logic [31:0] data, a, b, exp; int lat;
      a = rand_word(); b = rand_word(); exp = ref_alu(4'b0110, a, b);
      res_ready = 1'b0;
      run_op(1'b0, a, b, 4'b0110, 1'b0, ok, data, src, lat);
      checks++;
      if (!ok || data !== exp) begin errors++; $display("FAIL bp_result: data=%h required %h", data, exp); end
      r0_valid = 1'b1; r1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (res_data !== exp || {r0_ready, r1_ready, busy, res_valid} !== 4'b0011) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: data=%h ready0/ready1/busy/valid=%b required %h 0011",
                     i, res_data, {r0_ready, r1_ready, busy, res_valid}, exp);
         end
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_release: res_valid=%0d busy=%0d required 0 0", res_valid, busy);
      end
      r0_valid = 1'b1; r1_valid = 1'b1;
      #1;
      checks++;
      if ({r0_ready, r1_ready} !== (prio_m ? 2'b01 : 2'b10)) begin
         errors++; $display("FAIL bp_idle_grant: ready0/ready1=%b required %b", {r0_ready, r1_ready},
                            prio_m ? 2'b01 : 2'b10);
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_latency4();
      bit seen; int lat; logic [31:0] a, b;
      bit rose;
      d4_res_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         a = rand_word(); b = rand_word();
         d4_r0_a = a; d4_r0_b = b; d4_r0_op = 4'b0000; d4_r0_valid = 1'b1;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (d4_r0_ready) seen = 1'b1; end
         checks++;
         if (!seen) begin errors++; $display("FAIL lat4_accept pass %0d: ready never rose", pass); end
         @(posedge clk); #1;
         d4_r0_valid = 1'b0;
         if (pass == 0) begin
            seen = 1'b0; lat = 0;
            for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); lat++; #1; if (d4_res_valid) seen = 1'b1; end
            checks++;
            if (!seen || lat != 4 || d4_res_data !== a + b || d4_res_src !== 1'b0) begin
               errors++;
               $display("FAIL lat4_result: valid=%0d lat=%0d data=%h src=%0d required lat 4 data %h src 0",
                        seen, lat, d4_res_data, d4_res_src, a + b);
            end
            @(posedge clk); #1;
         end else begin
            @(posedge clk);
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            checks++;
            if (d4_busy !== 1'b0 || d4_res_valid !== 1'b0) begin
               errors++; $display("FAIL lat4_reset: busy=%0d res_valid=%0d required 0 0", d4_busy, d4_res_valid);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            prio_m = 1'b0;
            rose = 1'b0;
            for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (d4_res_valid) rose = 1'b1; end
            checks++;
            if (rose) begin errors++; $display("FAIL lat4_flush: res_valid rose after reset, required never"); end
            d4_r0_valid = 1'b1; d4_r1_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({d4_r0_ready, d4_r1_ready} !== 2'b10) begin
               errors++; $display("FAIL lat4_prio: ready0/ready1=%b required 10", {d4_r0_ready, d4_r1_ready});
            end
            d4_r0_valid = 1'b0; d4_r1_valid = 1'b0;
         end
      end
   endtask

   initial begin
      reset = 1'b1; res_ready = 1'b1; d4_res_ready = 1'b1;
      r0_valid = 1'b0; r1_valid = 1'b0; d4_r0_valid = 1'b0; d4_r1_valid = 1'b0;
      r0_a = 32'h0; r0_b = 32'h0; r0_op = 4'h0; r1_a = 32'h0; r1_b = 32'h0; r1_op = 4'h0;
      d4_r0_a = 32'h0; d4_r0_b = 32'h0; d4_r0_op = 4'h0; d4_r1_a = 32'h0; d4_r1_b = 32'h0; d4_r1_op = 4'h0;
      prio_m = 1'b0;
      test_reset();
      test_basic();
      do_reset();
      test_round_robin(2, 1'b1);
      test_round_robin(8, 1'b0);
      test_shifts();
      test_random_ops();
      test_backpressure();
      test_latency4();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
